// File: rtl/card_datapath.sv
// Card datapath for the baccarat table: a free-running dealer rank counter,
// six hand slots loaded by one-hot strobes, mod-10 hand scores, the player
// third-card value and a sticky flag for illegal load patterns.
module card_datapath (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [3:0] pcard3_value,
    output logic [2:0] cards_dealt,
    output logic       load_error
);

    localparam int unsigned RANK_W    = 4;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned SUM_W     = 5;
    localparam int unsigned NUM_SLOTS = 6;
    localparam logic [RANK_W-1:0] RANK_FIRST = RANK_W'(1);
    localparam logic [RANK_W-1:0] RANK_LAST  = RANK_W'(13);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(NUM_SLOTS);

    // Baccarat value of a rank: pips count face value, tens and faces count 0.
    function automatic logic [RANK_W-1:0] card_value(input logic [RANK_W-1:0] rank);
        return (rank <= RANK_W'(9)) ? rank : RANK_W'(0);
    endfunction

    // Mod-10 of a three-card sum (max 27) by conditional subtraction.
    function automatic logic [RANK_W-1:0] mod10(input logic [SUM_W-1:0] sum);
        logic [SUM_W-1:0] r;
        if (sum >= SUM_W'(20))      r = sum - SUM_W'(20);
        else if (sum >= SUM_W'(10)) r = sum - SUM_W'(10);
        else                        r = sum;
        return RANK_W'(r);
    endfunction

    // Slot order: 0..2 = player cards 1..3, 3..5 = dealer cards 1..3.
    logic [RANK_W-1:0] slot_q [NUM_SLOTS];
    logic [RANK_W-1:0] slot_d [NUM_SLOTS];
    logic [RANK_W-1:0] deal_rank_q, deal_rank_d;
    logic [CNT_W-1:0]  cards_dealt_q, cards_dealt_d;
    logic              load_error_q, load_error_d;

    logic [NUM_SLOTS-1:0] load_vec;
    logic [CNT_W-1:0]     load_cnt;
    logic [RANK_W-1:0]    sel_slot;

    assign load_vec = {load_dcard3, load_dcard2, load_dcard1,
                       load_pcard3, load_pcard2, load_pcard1};

    // Count active strobes and fetch the contents of the strobed slot.
    always_comb begin
        load_cnt = '0;
        sel_slot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            load_cnt = load_cnt + CNT_W'(load_vec[i]);
            if (load_vec[i]) sel_slot = slot_q[i];
        end
    end

    // Next state: rank counter always advances; one legal load captures the rank.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) slot_d[i] = slot_q[i];
        cards_dealt_d = cards_dealt_q;
        load_error_d  = load_error_q;
        deal_rank_d   = (deal_rank_q >= RANK_LAST) ? RANK_FIRST
                                                   : deal_rank_q + RANK_W'(1);
        if (load_cnt == CNT_W'(1)) begin
            if (sel_slot == '0 && cards_dealt_q < CNT_FULL) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (load_vec[i]) slot_d[i] = deal_rank_q;
                end
                cards_dealt_d = cards_dealt_q + CNT_W'(1);
            end else begin
                load_error_d = 1'b1;
            end
        end else if (load_cnt > CNT_W'(1)) begin
            load_error_d = 1'b1;
        end
    end

    // State registers with synchronous reset taking priority over loads.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
            deal_rank_q   <= RANK_FIRST;
            cards_dealt_q <= '0;
            load_error_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= slot_d[i];
            deal_rank_q   <= deal_rank_d;
            cards_dealt_q <= cards_dealt_d;
            load_error_q  <= load_error_d;
        end
    end

    assign pcard1      = slot_q[0];
    assign pcard2      = slot_q[1];
    assign pcard3      = slot_q[2];
    assign dcard1      = slot_q[3];
    assign dcard2      = slot_q[4];
    assign dcard3      = slot_q[5];
    assign cards_dealt = cards_dealt_q;
    assign load_error  = load_error_q;

    // Scores depend only on the slot registers, so a load is scored right after its edge.
    assign pscore = mod10(SUM_W'(card_value(slot_q[0])) + SUM_W'(card_value(slot_q[1]))
                        + SUM_W'(card_value(slot_q[2])));
    assign dscore = mod10(SUM_W'(card_value(slot_q[3])) + SUM_W'(card_value(slot_q[4]))
                        + SUM_W'(card_value(slot_q[5])));
    assign pcard3_value = card_value(slot_q[2]);

endmodule

// File: tb/tb_card_datapath.sv
// Scoreboard bench for card_datapath: a behavioural model predicts every
// cycle's outputs, which are queued at drive time and compared after the edge.
module tb_card_datapath;

    logic       slow_clock;
    logic       reset;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore, pcard3_value;
    logic [2:0] cards_dealt;
    logic       load_error;

    card_datapath dut (
        .slow_clock  (slow_clock),
        .reset       (reset),
        .load_pcard1 (load_pcard1),
        .load_pcard2 (load_pcard2),
        .load_pcard3 (load_pcard3),
        .load_dcard1 (load_dcard1),
        .load_dcard2 (load_dcard2),
        .load_dcard3 (load_dcard3),
        .pcard1      (pcard1),
        .pcard2      (pcard2),
        .pcard3      (pcard3),
        .dcard1      (dcard1),
        .dcard2      (dcard2),
        .dcard3      (dcard3),
        .pscore      (pscore),
        .dscore      (dscore),
        .pcard3_value(pcard3_value),
        .cards_dealt (cards_dealt),
        .load_error  (load_error)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    // Strobe encodings: bit 0..2 player 1..3, bit 3..5 dealer 1..3.
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] LP1  = 6'b000001;
    localparam logic [5:0] LP2  = 6'b000010;
    localparam logic [5:0] LP3  = 6'b000100;
    localparam logic [5:0] LD1  = 6'b001000;
    localparam logic [5:0] LD2  = 6'b010000;
    localparam logic [5:0] LD3  = 6'b100000;

    typedef struct {
        int slot [6];
        int pscore;
        int dscore;
        int p3val;
        int cards;
        int err;
    } exp_t;

    exp_t sb [$];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state.
    int m_slot [6];
    int m_rank;
    int m_cards;
    int m_err;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int bval(input int r);
        if (r >= 1 && r <= 9) return r;
        return 0;
    endfunction

    // Advance the model by one clock edge with the given strobes.
    task automatic model_edge(input logic [5:0] ld, input logic rst);
        int n;
        int idx;
        if (rst) begin
            foreach (m_slot[i]) m_slot[i] = 0;
            m_rank  = 1;
            m_cards = 0;
            m_err   = 0;
            return;
        end
        n   = $countones(ld);
        idx = -1;
        for (int i = 0; i < 6; i++) if (ld[i]) idx = i;
        if (n > 1) m_err = 1;
        else if (n == 1) begin
            if (m_slot[idx] != 0) m_err = 1;
            else begin
                m_slot[idx] = m_rank;
                m_cards++;
            end
        end
        m_rank = (m_rank % 13) + 1;
    endtask

    // Drive one cycle, queue the prediction, then compare after the edge.
    task automatic step(input logic [5:0] ld, input logic rst);
        exp_t e;
        exp_t g;
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = ld;
        reset = rst;
        model_edge(ld, rst);
        foreach (m_slot[i]) e.slot[i] = m_slot[i];
        e.pscore = (bval(m_slot[0]) + bval(m_slot[1]) + bval(m_slot[2])) % 10;
        e.dscore = (bval(m_slot[3]) + bval(m_slot[4]) + bval(m_slot[5])) % 10;
        e.p3val  = bval(m_slot[2]);
        e.cards  = m_cards;
        e.err    = m_err;
        sb.push_back(e);
        @(posedge slow_clock);
        #1;
        g = sb.pop_front();
        check_eq("pcard1", int'(pcard1), g.slot[0]);
        check_eq("pcard2", int'(pcard2), g.slot[1]);
        check_eq("pcard3", int'(pcard3), g.slot[2]);
        check_eq("dcard1", int'(dcard1), g.slot[3]);
        check_eq("dcard2", int'(dcard2), g.slot[4]);
        check_eq("dcard3", int'(dcard3), g.slot[5]);
        check_eq("pscore", int'(pscore), g.pscore);
        check_eq("dscore", int'(dscore), g.dscore);
        check_eq("pcard3_value", int'(pcard3_value), g.p3val);
        check_eq("cards_dealt", int'(cards_dealt), g.cards);
        check_eq("load_error", int'(load_error), g.err);
    endtask

    // Idle until the model's dealer rank equals r (bounded to one full lap).
    task automatic wait_rank(input int r);
        for (int k = 0; k < 14 && m_rank != r; k++) step(NONE, 1'b0);
        if (m_rank != r) check_eq("wait_rank", m_rank, r);
    endtask

    initial begin
        reset = 1'b1;
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = NONE;
        foreach (m_slot[i]) m_slot[i] = 0;
        m_rank = 1; m_cards = 0; m_err = 0;
        #2;

        // Reset state.
        step(NONE, 1'b1);
        check_eq("rst_cards", int'(cards_dealt), 0);
        check_eq("rst_err", int'(load_error), 0);

        // Four single loads from the first post-reset cycle: ranks 1..4.
        step(LP1, 1'b0);
        step(LD1, 1'b0);
        step(LP2, 1'b0);
        step(LD2, 1'b0);
        check_eq("t1_pscore", int'(pscore), 4);
        check_eq("t1_dscore", int'(dscore), 6);
        check_eq("t1_cards", int'(cards_dealt), 4);
        check_eq("t1_err", int'(load_error), 0);

        // Face cards score zero; counter wraps 13 -> 1.
        step(NONE, 1'b1);
        wait_rank(13);
        step(LP1, 1'b0);
        wait_rank(12);
        step(LP2, 1'b0);
        check_eq("t2_pcard1", int'(pcard1), 13);
        check_eq("t2_pcard2", int'(pcard2), 12);
        check_eq("t2_pscore", int'(pscore), 0);

        // Mod-10 wrap with 9+9+9, dealer 7+8.
        step(NONE, 1'b1);
        wait_rank(9); step(LP1, 1'b0);
        wait_rank(9); step(LP2, 1'b0);
        wait_rank(9); step(LP3, 1'b0);
        check_eq("t3_pscore", int'(pscore), 7);
        check_eq("t3_p3val", int'(pcard3_value), 9);
        wait_rank(7); step(LD1, 1'b0);
        wait_rank(8); step(LD2, 1'b0);
        check_eq("t3_dscore", int'(dscore), 5);

        // Two strobes at once, then a legal load, then a reload of a full slot.
        step(NONE, 1'b1);
        step(LP1 | LD1, 1'b0);
        check_eq("t4_pcard1", int'(pcard1), 0);
        check_eq("t4_err", int'(load_error), 1);
        wait_rank(5); step(LP1, 1'b0);
        check_eq("t4_pcard1_legal", int'(pcard1), 5);
        check_eq("t4_err_sticky", int'(load_error), 1);
        step(LP1, 1'b0);
        check_eq("t4_reload_pcard1", int'(pcard1), 5);
        check_eq("t4_reload_cards", int'(cards_dealt), 1);

        // Reset mid-round with a simultaneous load, then fill all slots and overflow.
        step(NONE, 1'b1);
        step(LP1, 1'b0); step(LD1, 1'b0); step(LP2, 1'b0);
        step(LD2, 1'b0); step(LP3, 1'b0);
        check_eq("t5_cards5", int'(cards_dealt), 5);
        step(LD3, 1'b1);
        check_eq("t5_rst_dcard3", int'(dcard3), 0);
        check_eq("t5_rst_cards", int'(cards_dealt), 0);
        step(LP1, 1'b0);
        check_eq("t5_first_rank", int'(pcard1), 1);
        step(LP2, 1'b0); step(LP3, 1'b0); step(LD1, 1'b0);
        step(LD2, 1'b0); step(LD3, 1'b0);
        check_eq("t5_full", int'(cards_dealt), 6);
        step(LD3, 1'b0);
        check_eq("t5_seventh_cards", int'(cards_dealt), 6);
        check_eq("t5_seventh_err", int'(load_error), 1);
        step(NONE, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
